cache_row_sync_engine: RTL and testbench
========================================

// Module: cache_row_sync_engine
// PURPOSE
//  Responder to the row-cache FSM's hold/sync protocol. On hold, it moves a row between the per-bank
//  row cache and backing memory: optional writeback of the victim row, then fill of the missed row.
//  When done, it pulses sync for the stalled bank. Sits between the row-cache FSM and the memory port.
// PARAMETERS
//  BGWIDTH    2   bank-group address width; BANKGROUPS = 2**BGWIDTH
//  BAWIDTH    2   bank address width; BANKSPERGROUP = 2**BAWIDTH
//  CHWIDTH    5   cache row index width (cache rows per bank = 2**CHWIDTH)
//  ADDRWIDTH  17  DRAM row address width
//  COLWIDTH   3   beats per row = 2**COLWIDTH
//  DWIDTH     64  beat data width
// PORTS
//  clk          in   1                     clock; all logic on rising edge
//  reset_n      in   1                     asynchronous active-low reset
//  hold         in   1                     row-cache miss stall request
//  bg           in   BGWIDTH               bank group of the miss; sampled on accept
//  ba           in   BAWIDTH               bank of the miss; sampled on accept
//  miss_rowid   in   ADDRWIDTH             DRAM row to fill
//  victim_rowid in   ADDRWIDTH             DRAM row held by the victim slot
//  victim_crow  in   CHWIDTH               cache slot being replaced
//  victim_dirty in   1                     victim slot was written
//  sync         out  2**(BGWIDTH+BAWIDTH)  one-hot per-bank completion; bit index {bg,ba}
//  busy         out  1                     engine not in IDLE
//  mem_req      out  1                     memory beat request
//  mem_we       out  1                     1 = write beat (writeback), 0 = read beat (fill)
//  mem_addr     out  BGWIDTH+BAWIDTH+ADDRWIDTH+COLWIDTH   {bg,ba,row,col}
//  mem_wdata    out  DWIDTH                writeback data
//  mem_ack      in   1                     beat accepted/complete
//  mem_rdata    in   DWIDTH                fill data; valid when mem_ack=1 and mem_we=0
//  cache_rd     out  1                     cache read strobe; data arrives next cycle
//  cache_we     out  1                     cache write strobe
//  cache_addr   out  BGWIDTH+BAWIDTH+CHWIDTH+COLWIDTH     {bg,ba,crow,col}
//  cache_wdata  out  DWIDTH                fill data to cache
//  cache_rdata  in   DWIDTH                cache read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: state IDLE; sync, busy, mem_req, mem_we, cache_rd, cache_we = 0; addrs, data, col counter = 0.
//  - IDLE: hold=1 -> latch bg, ba, miss_rowid, victim_rowid, victim_crow and victim_dirty; col=0.
//    Go to WB_RD when writeback is required, otherwise to FILL.
//  - WB_RD: cache_rd=1 for one cycle at {bg,ba,crow,col} -> WB_WR.
//  - WB_WR: next cycle, register cache_rdata into mem_wdata. Assert mem_req=1 with mem_we=1 and
//    mem_addr={bg,ba,victim_rowid,col}. Req, addr and data stay stable until mem_ack=1.
//    On ack: when col = max, set col=0 and go to FILL; otherwise col+1 and go to WB_RD.
//  - FILL: mem_req=1, mem_we=0, mem_addr={bg,ba,miss_rowid,col}, held until mem_ack. On ack,
//    register mem_rdata into cache_wdata and pulse cache_we=1 next cycle at {bg,ba,crow,col}.
//    mem_req drops for that cycle. On the last col -> DONE; otherwise col+1 and stay in FILL.
//  - DONE: sync[{bg,ba}]=1 for exactly one cycle; all other sync bits 0 -> RELEASE.
//  - RELEASE: wait for hold=0, then go to IDLE. This blocks re-triggering on a stale hold.
//  - mem_ack while mem_req=0 is ignored. The col counter wraps only on explicit reset to 0.
//  - If hold drops mid-transfer, it is ignored and the transfer completes. DONE still pulses;
//    RELEASE then exits immediately.
//  - bg, ba and row inputs that change after accept have no effect until the next IDLE accept.
//  - Asynchronous reset mid-transfer aborts at once. No partial sync is emitted.
//  - Latency with zero-wait ack, no writeback: accept to sync = 2*2**COLWIDTH + 2 cycles.
//  - busy=1 in every state except IDLE.
// CONFIGURATION
//  DIRTY_SKIP_EN defined: writeback runs only when victim_dirty=1; a clean victim goes straight to FILL.
//  DIRTY_SKIP_EN undefined: victim_dirty is ignored and writeback always runs before fill.
// TESTING
//  1. Reset held 2 cycles -> all outputs 0, busy=0. hold=0 for 10 cycles -> no mem_req.
//  2. hold=1, bg=1, ba=2, dirty=1, mem_ack tied 1 -> 8 write beats (mem_we=1, col 0..7,
//     row=victim_rowid), then 8 read beats with cache_we pulses. Then sync[6]=1 for one cycle.
//  3. DIRTY_SKIP_EN defined, dirty=0 -> no mem_we=1 beat; first mem_addr row=miss_rowid.
//     Same stimulus without the macro -> 8 writeback beats first.
//  4. mem_ack delayed 3 cycles per beat -> mem_req, mem_addr and mem_wdata stable while waiting.
//     cache_wdata equals each mem_rdata in col order.
//  5. hold kept high after sync -> no second transfer. Dropping hold, then re-raising it
//     with new bg/ba -> new transfer, sync on the new index.
//  6. reset_n=0 mid-FILL (col=4) -> mem_req, cache_we and busy = 0 immediately. No sync pulse.
//     After release, hold=1 -> transfer restarts at col 0.

Source files
------------

// File: rtl/cache_row_sync_engine_if.sv
// ----------------------------------------------------------------------------
// cache_row_sync_engine_if
// Bundles every non-clock signal of the row-cache sync engine:
//   - hold/sync handshake with the row-cache FSM, plus the miss/victim
//     descriptor (bg, ba, miss_rowid, victim_rowid, victim_crow, victim_dirty)
//   - memory beat port (mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata)
//   - row-cache data port (cache_rd/cache_we/cache_addr/cache_wdata,
//     cache_rdata with 1-cycle latency)
// Modports:
//   slave  : the sync engine (responds to hold, drives the memory/cache ports)
//   master : the environment (row-cache FSM, memory, cache storage)
// ----------------------------------------------------------------------------
interface cache_row_sync_engine_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 3,
  parameter int DWIDTH    = 64
);
  localparam int NBANK = 2 ** (BGWIDTH + BAWIDTH);
  localparam int MAW   = BGWIDTH + BAWIDTH + ADDRWIDTH + COLWIDTH;
  localparam int CAW   = BGWIDTH + BAWIDTH + CHWIDTH + COLWIDTH;

  logic                 hold;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic [ADDRWIDTH-1:0] miss_rowid;
  logic [ADDRWIDTH-1:0] victim_rowid;
  logic [CHWIDTH-1:0]   victim_crow;
  logic                 victim_dirty;
  logic [NBANK-1:0]     sync;
  logic                 busy;

  logic                 mem_req;
  logic                 mem_we;
  logic [MAW-1:0]       mem_addr;
  logic [DWIDTH-1:0]    mem_wdata;
  logic                 mem_ack;
  logic [DWIDTH-1:0]    mem_rdata;

  logic                 cache_rd;
  logic                 cache_we;
  logic [CAW-1:0]       cache_addr;
  logic [DWIDTH-1:0]    cache_wdata;
  logic [DWIDTH-1:0]    cache_rdata;

  modport slave (
    input  hold, bg, ba, miss_rowid, victim_rowid, victim_crow, victim_dirty,
    input  mem_ack, mem_rdata, cache_rdata,
    output sync, busy, mem_req, mem_we, mem_addr, mem_wdata,
    output cache_rd, cache_we, cache_addr, cache_wdata
  );

  modport master (
    output hold, bg, ba, miss_rowid, victim_rowid, victim_crow, victim_dirty,
    output mem_ack, mem_rdata, cache_rdata,
    input  sync, busy, mem_req, mem_we, mem_addr, mem_wdata,
    input  cache_rd, cache_we, cache_addr, cache_wdata
  );
endinterface

// File: rtl/cache_row_sync_engine.sv
// ----------------------------------------------------------------------------
// cache_row_sync_engine
// Services a row-cache miss stall: on hold it optionally writes the victim row
// back to memory (one cache read + one memory write per beat), then fills the
// missed row (one memory read + one cache write per beat), then pulses the
// per-bank sync bit {bg,ba} for one cycle and waits for hold to drop.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : hold/sync handshake, miss/victim descriptor, memory beat
//                  port and row-cache data port (see cache_row_sync_engine_if)
// Configuration:
//   DIRTY_SKIP_EN : when defined, a clean victim skips the writeback phase;
//                   when undefined, writeback always precedes the fill.
// All outputs are registered.
// ----------------------------------------------------------------------------
module cache_row_sync_engine #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 3,
  parameter int DWIDTH    = 64
) (
  input logic                    clk,
  input logic                    reset_n,
  cache_row_sync_engine_if.slave bus
);
  localparam int NBANK = 2 ** (BGWIDTH + BAWIDTH);
  localparam int MAW   = BGWIDTH + BAWIDTH + ADDRWIDTH + COLWIDTH;
  localparam int CAW   = BGWIDTH + BAWIDTH + CHWIDTH + COLWIDTH;
  localparam logic [NBANK-1:0]    SYNC_ONE = NBANK'(1);
  localparam logic [COLWIDTH-1:0] COL_MAX  = '1;

`ifdef DIRTY_SKIP_EN
  localparam bit DIRTY_SKIP = 1'b1;
`else
  localparam bit DIRTY_SKIP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_WR,
    S_FILL,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t               r_state;
  logic [BGWIDTH-1:0]   r_bg;
  logic [BAWIDTH-1:0]   r_ba;
  logic [ADDRWIDTH-1:0] r_miss_row;
  logic [ADDRWIDTH-1:0] r_victim_row;
  logic [CHWIDTH-1:0]   r_crow;
  logic [COLWIDTH-1:0]  r_col;

  logic [NBANK-1:0]     r_sync;
  logic                 r_busy;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [MAW-1:0]       r_mem_addr;
  logic [DWIDTH-1:0]    r_mem_wdata;
  logic                 r_cache_rd;
  logic                 r_cache_we;
  logic [CAW-1:0]       r_cache_addr;
  logic [DWIDTH-1:0]    r_cache_wdata;

  logic                 w_need_wb;
  logic [COLWIDTH-1:0]  w_col_nxt;
  logic [NBANK-1:0]     w_sync_bit;

  // A clean victim only skips writeback when the skip feature is built in.
  assign w_need_wb  = bus.victim_dirty | ~DIRTY_SKIP;
  assign w_col_nxt  = r_col + 1'b1;
  assign w_sync_bit = SYNC_ONE << {r_bg, r_ba};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of all r_ registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_bg          <= '0;
      r_ba          <= '0;
      r_miss_row    <= '0;
      r_victim_row  <= '0;
      r_crow        <= '0;
      r_col         <= '0;
      r_sync        <= '0;
      r_busy        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cache_rd    <= 1'b0;
      r_cache_we    <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_wdata <= '0;
    end else begin
      // sync is a single-cycle pulse: cleared every cycle unless DONE sets it.
      r_sync <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.hold) begin
            r_bg         <= bus.bg;
            r_ba         <= bus.ba;
            r_miss_row   <= bus.miss_rowid;
            r_victim_row <= bus.victim_rowid;
            r_crow       <= bus.victim_crow;
            r_col        <= '0;
            r_busy       <= 1'b1;
            if (w_need_wb) begin
              // cache_rd is visible during the WB_RD cycle itself.
              r_cache_rd   <= 1'b1;
              r_cache_addr <= {bus.bg, bus.ba, bus.victim_crow, {COLWIDTH{1'b0}}};
              r_state      <= S_WB_RD;
            end else begin
              r_state <= S_FILL;
            end
          end
        end

        S_WB_RD: begin
          r_cache_rd <= 1'b0;
          r_state    <= S_WB_WR;
        end

        S_WB_WR: begin
          if (!r_mem_req) begin
            // First WB_WR cycle: the cache read issued in WB_RD is valid now.
            r_mem_wdata <= bus.cache_rdata;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_bg, r_ba, r_victim_row, r_col};
          end else if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_col == COL_MAX) begin
              r_col   <= '0;
              r_state <= S_FILL;
            end else begin
              r_col        <= w_col_nxt;
              r_cache_rd   <= 1'b1;
              r_cache_addr <= {r_bg, r_ba, r_crow, w_col_nxt};
              r_state      <= S_WB_RD;
            end
          end
        end

        S_FILL: begin
          if (r_cache_we) begin
            // Cache write cycle; the next read beat is issued straight away.
            r_cache_we <= 1'b0;
            if (r_col == COL_MAX) begin
              r_state <= S_DONE;
            end else begin
              r_col      <= w_col_nxt;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {r_bg, r_ba, r_miss_row, w_col_nxt};
            end
          end else if (!r_mem_req) begin
            // Entry into FILL: issue the first read beat.
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_bg, r_ba, r_miss_row, r_col};
          end else if (bus.mem_ack) begin
            r_mem_req     <= 1'b0;
            r_cache_wdata <= bus.mem_rdata;
            r_cache_we    <= 1'b1;
            r_cache_addr  <= {r_bg, r_ba, r_crow, r_col};
          end
        end

        S_DONE: begin
          r_sync  <= w_sync_bit;
          r_state <= S_RELEASE;
        end

        S_RELEASE: begin
          // Waiting for hold to drop prevents re-accepting the same stall.
          if (!bus.hold) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sync        = r_sync;
  assign bus.busy        = r_busy;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.cache_rd    = r_cache_rd;
  assign bus.cache_we    = r_cache_we;
  assign bus.cache_addr  = r_cache_addr;
  assign bus.cache_wdata = r_cache_wdata;
endmodule

// File: tb/tb_cache_row_sync_engine.sv
// ----------------------------------------------------------------------------
// tb_cache_row_sync_engine
// Scoreboard bench: each started transfer pushes its expected memory beats,
// cache writes and sync pulse into queues; a negedge monitor compares DUT
// activity against the queue heads. A memory model (tied or delayed ack) and
// a cache storage model (1-cycle read latency) respond to the DUT.
// Honours DIRTY_SKIP_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_cache_row_sync_engine;
  localparam int NB   = 16;
  localparam int MAW  = 24;
  localparam int CAW  = 12;
  localparam int DW   = 64;
  localparam int NCOL = 8;

`ifdef DIRTY_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_row_sync_engine_if bus ();

  cache_row_sync_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic           we;
    logic [MAW-1:0] addr;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic [CAW-1:0] addr;
    logic [DW-1:0]  data;
  } cwr_t;

  beat_t          mem_q[$];
  cwr_t           cwr_q[$];
  logic [NB-1:0]  sync_q[$];

  logic [DW-1:0]  cmem [0:4095];
  logic [DW-1:0]  gold [0:4095];
  logic [DW-1:0]  saved_old [0:NCOL-1];

  int ack_wait = 0;
  int wcnt = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int exp_lat = 0;
  bit expect_latency = 1'b0;
  bit sync_seen = 1'b0;

  function automatic logic [DW-1:0] cinit(input int a);
    return {32'hCAFE_0000 | 32'(a), 32'h1234_0000 ^ 32'(a)};
  endfunction

  function automatic logic [DW-1:0] memf(input logic [MAW-1:0] a);
    return {a, 16'h5A5A, a};
  endfunction

  // Memory model: ack tied high when ack_wait is 0, else after ack_wait waits.
  assign bus.mem_ack   = (ack_wait == 0) ? 1'b1 : (bus.mem_req && (wcnt == ack_wait));
  assign bus.mem_rdata = memf(bus.mem_addr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.cache_rd) bus.cache_rdata <= cmem[bus.cache_addr];
    if (bus.cache_we) cmem[bus.cache_addr] <= bus.cache_wdata;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_req) begin
        if (mem_q.size() == 0) begin
          check("spurious_mem_req", {63'b0, bus.mem_req}, 64'd0);
        end else begin
          check("mem_we", {63'b0, bus.mem_we}, {63'b0, mem_q[0].we});
          check("mem_addr", 64'(bus.mem_addr), 64'(mem_q[0].addr));
          if (mem_q[0].we) check("mem_wdata", bus.mem_wdata, mem_q[0].data);
          if (bus.mem_ack) void'(mem_q.pop_front());
        end
      end
      if (bus.cache_we) begin
        if (cwr_q.size() == 0) begin
          check("spurious_cache_we", {63'b0, bus.cache_we}, 64'd0);
        end else begin
          check("cache_addr", 64'(bus.cache_addr), 64'(cwr_q[0].addr));
          check("cache_wdata", bus.cache_wdata, cwr_q[0].data);
          void'(cwr_q.pop_front());
        end
      end
      if (bus.sync != '0) begin
        sync_seen = 1'b1;
        if (sync_q.size() == 0) begin
          check("spurious_sync", 64'(bus.sync), 64'd0);
        end else begin
          check("sync", 64'(bus.sync), 64'(sync_q.pop_front()));
          if (expect_latency) check("latency", 64'(cyc - accept_cyc), 64'(exp_lat));
        end
      end
    end
  end

  task automatic start_xfer(input logic [1:0] bg, input logic [1:0] ba, input logic [4:0] crow,
                            input logic [16:0] vrow, input logic [16:0] mrow, input logic dirty);
    logic           wb;
    logic [CAW-1:0] ci;
    logic [MAW-1:0] ma;
    wb = dirty | ~SKIP;
    for (int c = 0; c < NCOL; c++) begin
      ci = {bg, ba, crow, 3'(c)};
      saved_old[c] = gold[ci];
      if (wb) begin
        ma = {bg, ba, vrow, 3'(c)};
        mem_q.push_back(beat_t'{we: 1'b1, addr: ma, data: gold[ci]});
      end
    end
    for (int c = 0; c < NCOL; c++) begin
      ci = {bg, ba, crow, 3'(c)};
      ma = {bg, ba, mrow, 3'(c)};
      mem_q.push_back(beat_t'{we: 1'b0, addr: ma, data: '0});
      cwr_q.push_back(cwr_t'{addr: ci, data: memf(ma)});
      gold[ci] = memf(ma);
    end
    sync_q.push_back(NB'(1) << {bg, ba});
    exp_lat = (wb ? 3 * NCOL : 0) + 2 * NCOL + 2;
    expect_latency = (ack_wait == 0);
    sync_seen = 1'b0;
    @(negedge clk);
    bus.bg           = bg;
    bus.ba           = ba;
    bus.victim_crow  = crow;
    bus.victim_rowid = vrow;
    bus.miss_rowid   = mrow;
    bus.victim_dirty = dirty;
    bus.hold         = 1'b1;
    accept_cyc       = cyc + 1;
  endtask

  task automatic wait_sync(input int budget);
    for (int i = 0; i < budget && !sync_seen; i++) begin
      @(negedge clk);
      #1;
    end
    check("sync_seen", {63'b0, sync_seen}, 64'd1);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("cwr_q_drained", 64'(cwr_q.size()), 64'd0);
  endtask

  task automatic finish_xfer();
    bus.hold = 1'b0;
    for (int i = 0; i < 4 && bus.busy; i++) @(negedge clk);
    #1;
    check("busy_idle", {63'b0, bus.busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    for (int i = 0; i < 4096; i++) begin
      cmem[i] = cinit(i);
      gold[i] = cinit(i);
    end
    bus.hold = 1'b0; bus.bg = '0; bus.ba = '0; bus.miss_rowid = '0;
    bus.victim_rowid = '0; bus.victim_crow = '0; bus.victim_dirty = 1'b0;
    bus.cache_rdata = '0;

    // 1. reset state, then idle with hold low
    repeat (2) @(negedge clk);
    check("rst_sync", 64'(bus.sync), 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_mem_req", {63'b0, bus.mem_req}, 64'd0);
    check("rst_mem_we", {63'b0, bus.mem_we}, 64'd0);
    check("rst_cache_rd", {63'b0, bus.cache_rd}, 64'd0);
    check("rst_cache_we", {63'b0, bus.cache_we}, 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_cache_addr", 64'(bus.cache_addr), 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", {63'b0, bus.busy}, 64'd0);
    check("idle_mem_req", {63'b0, bus.mem_req}, 64'd0);

    // 2. dirty victim, zero-wait memory, sync on bit 6
    start_xfer(2'd1, 2'd2, 5'd3, 17'h01234, 17'h00ABC, 1'b1);
    wait_sync(400);
    finish_xfer();

    // 3. clean victim: writeback skipped only when DIRTY_SKIP_EN is built in
    start_xfer(2'd0, 2'd1, 5'd7, 17'h1FFFF, 17'h00555, 1'b0);
    wait_sync(400);
    finish_xfer();

    // 4. delayed ack; hold dropped mid-transfer, release must be immediate
    ack_wait = 3;
    start_xfer(2'd3, 2'd3, 5'd31, 17'h0F0F0, 17'h10101, 1'b1);
    repeat (5) @(negedge clk);
    bus.hold = 1'b0;
    wait_sync(600);
    @(negedge clk);
    #1;
    check("release_immediate", {63'b0, bus.busy}, 64'd0);
    ack_wait = 0;

    // 5. stale hold blocks retrigger; new bank after hold drops (reuses slot of 2)
    start_xfer(2'd2, 2'd0, 5'd0, 17'h00001, 17'h00002, 1'b1);
    wait_sync(400);
    repeat (20) @(negedge clk);
    #1;
    check("stale_hold_busy", {63'b0, bus.busy}, 64'd1);
    finish_xfer();
    start_xfer(2'd1, 2'd2, 5'd3, 17'h00AAA, 17'h0BBBB, 1'b1);
    wait_sync(400);
    finish_xfer();

    // 6. async reset mid-fill at col 4, then restart from col 0
    start_xfer(2'd0, 2'd3, 5'd9, 17'h03333, 17'h04444, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #1;
      found = bus.mem_req && !bus.mem_we && (bus.mem_addr[2:0] == 3'd4);
    end
    check("reached_fill_col4", {63'b0, found}, 64'd1);
    reset_n = 1'b0;
    bus.hold = 1'b0;
    #1;
    check("abort_mem_req", {63'b0, bus.mem_req}, 64'd0);
    check("abort_cache_we", {63'b0, bus.cache_we}, 64'd0);
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_sync", 64'(bus.sync), 64'd0);
    mem_q.delete();
    cwr_q.delete();
    sync_q.delete();
    // Only cols 0..3 reached the cache before the abort.
    for (int c = 4; c < NCOL; c++) gold[{2'd0, 2'd3, 5'd9, 3'(c)}] = saved_old[c];
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_sync_quiet", {63'b0, sync_seen}, 64'd0);
    start_xfer(2'd0, 2'd3, 5'd9, 17'h03333, 17'h04444, 1'b1);
    wait_sync(400);
    finish_xfer();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
